// File: rtl/axi_isolate_seq_multi.sv
// Per-channel AXI isolation sequencer: synchronises the isolate request, tracks outstanding
// write/read bursts and gates new AW/AR until the channel drains or the drain timer expires.
module axi_isolate_seq_multi #(
    parameter int NumChan       = 2,
    parameter int SyncStages    = 3,
    parameter int MaxPending    = 4,
    parameter int TimeoutCycles = 256,
    parameter int ResetIsolated = 1,
    parameter int CntW          = $clog2(MaxPending + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumChan-1:0]      isolate_i,
    input  logic [NumChan-1:0]      aw_hs_i,
    input  logic [NumChan-1:0]      b_hs_i,
    input  logic [NumChan-1:0]      ar_hs_i,
    input  logic [NumChan-1:0]      r_last_hs_i,
    output logic [NumChan-1:0]      gate_aw_o,
    output logic [NumChan-1:0]      gate_ar_o,
    output logic [NumChan-1:0]      isolated_o,
    output logic [NumChan-1:0]      timeout_o,
    output logic [NumChan*CntW-1:0] wr_pend_o,
    output logic [NumChan*CntW-1:0] rd_pend_o
);

    localparam int TmrW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxPending);
    localparam logic            RstIso  = (ResetIsolated != 0);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ISOLATED
    } chan_state_e;

    // Simultaneous issue and retire cancel; saturate at both ends.
    function automatic logic [CntW-1:0] next_count(input logic [CntW-1:0] cur,
                                                   input logic            issue,
                                                   input logic            retire);
        logic [CntW-1:0] nxt;
        nxt = cur;
        if (issue && !retire && (cur != CntMax)) begin
            nxt = cur + CntW'(1);
        end else if (retire && !issue && (cur != '0)) begin
            nxt = cur - CntW'(1);
        end
        return nxt;
    endfunction

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        logic [SyncStages-1:0] sync_q;
        logic                  iso_s;
        chan_state_e           state_q;
        logic [CntW-1:0]       wr_q;
        logic [CntW-1:0]       rd_q;
        logic [CntW-1:0]       wr_nxt;
        logic [CntW-1:0]       rd_nxt;
        logic [TmrW-1:0]       timer_q;
        logic                  gate_aw_q;
        logic                  gate_ar_q;
        logic                  isolated_q;
        logic                  timeout_q;

        assign iso_s  = sync_q[SyncStages-1];
        assign wr_nxt = next_count(wr_q, aw_hs_i[c], b_hs_i[c]);
        assign rd_nxt = next_count(rd_q, ar_hs_i[c], r_last_hs_i[c]);

        // Gates are registered from the next counter value so they line up with wr/rd_pend.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync_q     <= {SyncStages{RstIso}};
                state_q    <= RstIso ? ST_ISOLATED : ST_RUN;
                wr_q       <= '0;
                rd_q       <= '0;
                timer_q    <= '0;
                gate_aw_q  <= RstIso;
                gate_ar_q  <= RstIso;
                isolated_q <= RstIso;
                timeout_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SyncStages-2:0], isolate_i[c]};
                wr_q   <= wr_nxt;
                rd_q   <= rd_nxt;
                case (state_q)
                    ST_RUN: begin
                        isolated_q <= 1'b0;
                        if (iso_s) begin
                            state_q   <= ST_DRAIN;
                            timer_q   <= '0;
                            gate_aw_q <= 1'b1;
                            gate_ar_q <= 1'b1;
                        end else begin
                            gate_aw_q <= (wr_nxt == CntMax);
                            gate_ar_q <= (rd_nxt == CntMax);
                        end
                    end
                    ST_DRAIN: begin
                        if (!iso_s) begin
                            state_q   <= ST_RUN;
                            timer_q   <= '0;
                            gate_aw_q <= (wr_nxt == CntMax);
                            gate_ar_q <= (rd_nxt == CntMax);
                        end else if ((wr_nxt == '0) && (rd_nxt == '0)) begin
                            state_q    <= ST_ISOLATED;
                            isolated_q <= 1'b1;
                        end else if (timer_q == TmrLast) begin
                            state_q    <= ST_ISOLATED;
                            isolated_q <= 1'b1;
                            timeout_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TmrW'(1);
                        end
                    end
                    ST_ISOLATED: begin
                        if (!iso_s) begin
                            state_q    <= ST_RUN;
                            timer_q    <= '0;
                            isolated_q <= 1'b0;
                            timeout_q  <= 1'b0;
                            gate_aw_q  <= (wr_nxt == CntMax);
                            gate_ar_q  <= (rd_nxt == CntMax);
                        end
                    end
                    default: begin
                        state_q    <= ST_ISOLATED;
                        gate_aw_q  <= 1'b1;
                        gate_ar_q  <= 1'b1;
                        isolated_q <= 1'b1;
                    end
                endcase
            end
        end

        assign gate_aw_o[c]                = gate_aw_q;
        assign gate_ar_o[c]                = gate_ar_q;
        assign isolated_o[c]               = isolated_q;
        assign timeout_o[c]                = timeout_q;
        assign wr_pend_o[c*CntW +: CntW]   = wr_q;
        assign rd_pend_o[c*CntW +: CntW]   = rd_q;
    end

endmodule

// File: tb/tb_axi_isolate_seq_multi.sv
// Directed bench for axi_isolate_seq_multi: stimulus queues expected outputs with a due
// cycle, and a negedge monitor pops and compares them against the DUT.
module tb_axi_isolate_seq_multi;

    localparam int NumChan = 2;
    localparam int CntW    = 3;

    localparam int F_GAW = 0;
    localparam int F_GAR = 1;
    localparam int F_ISO = 2;
    localparam int F_TO  = 3;
    localparam int F_WR  = 4;
    localparam int F_RD  = 5;

    typedef struct {
        int    due;
        string name;
        int    field;
        int    ch;
        int    exp;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NumChan-1:0]      isolate;
    logic [NumChan-1:0]      aw_hs;
    logic [NumChan-1:0]      b_hs;
    logic [NumChan-1:0]      ar_hs;
    logic [NumChan-1:0]      r_last_hs;
    logic [NumChan-1:0]      gate_aw;
    logic [NumChan-1:0]      gate_ar;
    logic [NumChan-1:0]      isolated;
    logic [NumChan-1:0]      timeout;
    logic [NumChan*CntW-1:0] wr_pend;
    logic [NumChan*CntW-1:0] rd_pend;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    axi_isolate_seq_multi #(
        .NumChan      (2),
        .SyncStages   (3),
        .MaxPending   (4),
        .TimeoutCycles(256),
        .ResetIsolated(1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .isolate_i   (isolate),
        .aw_hs_i     (aw_hs),
        .b_hs_i      (b_hs),
        .ar_hs_i     (ar_hs),
        .r_last_hs_i (r_last_hs),
        .gate_aw_o   (gate_aw),
        .gate_ar_o   (gate_ar),
        .isolated_o  (isolated),
        .timeout_o   (timeout),
        .wr_pend_o   (wr_pend),
        .rd_pend_o   (rd_pend)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_actual(input int field, input int ch);
        case (field)
            F_GAW:   return int'(gate_aw[ch]);
            F_GAR:   return int'(gate_ar[ch]);
            F_ISO:   return int'(isolated[ch]);
            F_TO:    return int'(timeout[ch]);
            F_WR:    return int'(wr_pend[ch*CntW +: CntW]);
            default: return int'(rd_pend[ch*CntW +: CntW]);
        endcase
    endfunction

    // Monitor: compare every queued expectation that falls due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                int act;
                act = get_actual(sb[i].field, sb[i].ch);
                n_cmp++;
                if (sb[i].due < cyc) begin
                    n_err++;
                    $display("[TB] FAIL %s: missed due cycle %0d (now %0d)", sb[i].name, sb[i].due, cyc);
                end else if (act != sb[i].exp) begin
                    n_err++;
                    $display("[TB] FAIL %s @cyc %0d: got %0d expected %0d", sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] aw, input logic [1:0] b,
                                 input logic [1:0] ar, input logic [1:0] rl);
        aw_hs     = aw;
        b_hs      = b;
        ar_hs     = ar;
        r_last_hs = rl;
        tick(1);
        aw_hs     = '0;
        b_hs      = '0;
        ar_hs     = '0;
        r_last_hs = '0;
    endtask

    task automatic checkOutput(input string name, input int offset, input int field,
                               input int ch, input int exp);
        exp_t e;
        e.due   = cyc + offset;
        e.name  = name;
        e.field = field;
        e.ch    = ch;
        e.exp   = exp;
        sb.push_back(e);
    endtask

    initial begin
        rst       = 1'b1;
        isolate   = '0;
        aw_hs     = '0;
        b_hs      = '0;
        ar_hs     = '0;
        r_last_hs = '0;
        tick(2);

        checkOutput("rst_iso0", 0, F_ISO, 0, 1);
        checkOutput("rst_iso1", 0, F_ISO, 1, 1);
        checkOutput("rst_gaw1", 0, F_GAW, 1, 1);
        checkOutput("rst_gar0", 0, F_GAR, 0, 1);
        checkOutput("rst_to0",  0, F_TO,  0, 0);
        checkOutput("rst_wr0",  0, F_WR,  0, 0);
        rst = 1'b0;
        checkOutput("t1_iso0_c3", 3, F_ISO, 0, 1);
        checkOutput("t1_iso0_c4", 4, F_ISO, 0, 0);
        checkOutput("t1_gaw0_c4", 4, F_GAW, 0, 0);
        checkOutput("t1_gar1_c3", 3, F_GAR, 1, 1);
        checkOutput("t1_gar1_c4", 4, F_GAR, 1, 0);
        tick(6);

        // Write counter ceiling on ch0
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("t2_wr0_3",   0, F_WR,  0, 3);
        checkOutput("t2_gaw0_3",  0, F_GAW, 0, 0);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("t2_wr0_4",   0, F_WR,  0, 4);
        checkOutput("t2_gaw0_4",  0, F_GAW, 0, 1);
        checkOutput("t2_gar0_4",  0, F_GAR, 0, 0);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("t2_wr0_ceil", 0, F_WR, 0, 4);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
        checkOutput("t2_wr0_ret",  0, F_WR,  0, 3);
        checkOutput("t2_gaw0_ret", 0, F_GAW, 0, 0);

        // Read counter ceiling and hold on ch1
        for (int i = 0; i < 5; i++) applyStimulus(2'b00, 2'b00, 2'b10, 2'b00);
        checkOutput("rd1_ceil",  0, F_RD,  1, 4);
        checkOutput("gar1_ceil", 0, F_GAR, 1, 1);
        checkOutput("gaw1_ceil", 0, F_GAW, 1, 0);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b10);
        checkOutput("rd1_hold4", 0, F_RD, 1, 4);
        for (int i = 0; i < 4; i++) applyStimulus(2'b00, 2'b00, 2'b00, 2'b10);
        checkOutput("rd1_empty",  0, F_RD,  1, 0);
        checkOutput("gar1_empty", 0, F_GAR, 1, 0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b10);
        checkOutput("rd1_floor", 0, F_RD, 1, 0);

        // Simultaneous issue/retire and floor on ch0
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
        checkOutput("t5_wr0_1", 0, F_WR, 0, 1);
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00);
        checkOutput("t5_wr0_hold", 0, F_WR, 0, 1);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
        checkOutput("t5_wr0_0", 0, F_WR, 0, 0);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
        checkOutput("t5_wr0_floor", 0, F_WR, 0, 0);

        // Drain completes on ch0
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("t3_wr0_2", 0, F_WR, 0, 2);
        isolate[0] = 1'b1;
        checkOutput("t3_gaw0_p3",  3,  F_GAW, 0, 0);
        checkOutput("t3_gaw0_p4",  4,  F_GAW, 0, 1);
        checkOutput("t3_gar0_p4",  4,  F_GAR, 0, 1);
        checkOutput("t3_iso0_p4",  4,  F_ISO, 0, 0);
        checkOutput("t3_wr0_p12",  12, F_WR,  0, 1);
        checkOutput("t3_iso0_p12", 12, F_ISO, 0, 0);
        checkOutput("t3_iso0_p13", 13, F_ISO, 0, 1);
        checkOutput("t3_wr0_p13",  13, F_WR,  0, 0);
        checkOutput("t3_to0_p13",  13, F_TO,  0, 0);
        checkOutput("t3_gaw1_p13", 13, F_GAW, 1, 0);
        tick(10);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
        tick(1);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
        tick(3);
        isolate[0] = 1'b0;
        checkOutput("t3_rel_iso0_p3", 3, F_ISO, 0, 1);
        checkOutput("t3_rel_iso0_p4", 4, F_ISO, 0, 0);
        checkOutput("t3_rel_gaw0_p4", 4, F_GAW, 0, 0);
        tick(6);

        // Abort mid-drain on ch0, then re-enter and time out
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        isolate[0] = 1'b1;
        checkOutput("t5_ab_gaw0_p4", 4, F_GAW, 0, 1);
        tick(8);
        isolate[0] = 1'b0;
        checkOutput("t5_ab_gaw0_p3", 3, F_GAW, 0, 1);
        checkOutput("t5_ab_gaw0_p4", 4, F_GAW, 0, 0);
        checkOutput("t5_ab_iso0_p4", 4, F_ISO, 0, 0);
        tick(6);
        isolate[0] = 1'b1;
        checkOutput("t5_re_gaw0_p4",   4,   F_GAW, 0, 1);
        checkOutput("t5_re_iso0_p259", 259, F_ISO, 0, 0);
        checkOutput("t5_re_to0_p259",  259, F_TO,  0, 0);
        checkOutput("t5_re_iso0_p260", 260, F_ISO, 0, 1);
        checkOutput("t5_re_to0_p260",  260, F_TO,  0, 1);
        tick(262);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
        checkOutput("late_b_wr0",  0, F_WR,  0, 0);
        checkOutput("late_b_iso0", 0, F_ISO, 0, 1);
        isolate[0] = 1'b0;
        checkOutput("to_exit_to0_p3", 3, F_TO,  0, 1);
        checkOutput("to_exit_to0_p4", 4, F_TO,  0, 0);
        checkOutput("to_exit_iso0",   4, F_ISO, 0, 0);
        tick(6);

        // Read-side timeout on ch1 while ch0 keeps running
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b00);
        isolate[1] = 1'b1;
        checkOutput("t4_gar1_p4",   4,   F_GAR, 1, 1);
        checkOutput("t4_iso1_p259", 259, F_ISO, 1, 0);
        checkOutput("t4_iso1_p260", 260, F_ISO, 1, 1);
        checkOutput("t4_to1_p260",  260, F_TO,  1, 1);
        checkOutput("t4_rd1_p260",  260, F_RD,  1, 1);
        checkOutput("t4_gaw0_p260", 260, F_GAW, 0, 0);
        checkOutput("t4_iso0_p260", 260, F_ISO, 0, 0);
        tick(262);
        isolate[1] = 1'b0;
        checkOutput("t4_rel_to1",  4, F_TO,  1, 0);
        checkOutput("t4_rel_iso1", 4, F_ISO, 1, 0);
        checkOutput("t4_rel_gar1", 4, F_GAR, 1, 0);
        tick(6);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b10);
        checkOutput("t4_rd1_clear", 0, F_RD, 1, 0);

        // Drain completes on the very cycle the timer would expire
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b00);
        isolate[1] = 1'b1;
        checkOutput("prio_iso1_p259", 259, F_ISO, 1, 0);
        checkOutput("prio_iso1_p260", 260, F_ISO, 1, 1);
        checkOutput("prio_to1_p260",  260, F_TO,  1, 0);
        checkOutput("prio_rd1_p260",  260, F_RD,  1, 0);
        tick(259);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b10);
        tick(2);
        isolate[1] = 1'b0;
        tick(6);

        // Reset pulsed mid-drain on ch1
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, 2'b00, 2'b10, 2'b00);
        checkOutput("t6_rd1_3", 0, F_RD, 1, 3);
        isolate[1] = 1'b1;
        tick(6);
        checkOutput("t6_iso1_drain", 0, F_ISO, 1, 0);
        checkOutput("t6_gar1_drain", 0, F_GAR, 1, 1);
        rst = 1'b1;
        checkOutput("t6_rd1_rst",  1, F_RD,  1, 0);
        checkOutput("t6_iso1_rst", 1, F_ISO, 1, 1);
        checkOutput("t6_to1_rst",  1, F_TO,  1, 0);
        checkOutput("t6_iso0_rst", 1, F_ISO, 0, 1);
        checkOutput("t6_gaw0_rst", 1, F_GAW, 0, 1);
        tick(1);
        rst     = 1'b0;
        isolate = '0;
        tick(2);

        for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
        while (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL %s: never compared (due %0d)", sb[0].name, sb[0].due);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
